// File: rtl/rr_reg_write_arbiter.sv
// Round-robin write arbiter driving a shared flip-flop register bank.
// Optional ownership lock/streaming enabled with `define RR_ARB_LOCK_EN.
module rr_reg_write_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = 2,
    parameter int DATA_W  = 8
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [NUM_REQ*ADDR_W-1:0]  req_addr,
    input  logic [NUM_REQ*DATA_W-1:0]  req_data,
    input  logic [NUM_REQ-1:0]         lock,
    output logic [NUM_REQ-1:0]         ack,
    output logic [(2**ADDR_W)-1:0]     wr_en,
    output logic [DATA_W-1:0]          wr_data,
    output logic                       busy
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {
        IDLE,
        GRANT,
        LOCKED
    } state_t;

    state_t               state, state_n;
    logic [PTR_W-1:0]     ptr, ptr_n;
    logic [NUM_REQ-1:0]   elig;
    logic [NUM_REQ-1:0]   ack_n;
    logic [DEPTH-1:0]     wr_en_n;
    logic [DATA_W-1:0]    wr_data_n;
    logic                 busy_n;
    logic                 found;
    logic [PTR_W-1:0]     w;
    logic [ADDR_W-1:0]    w_addr;
    int                   idx;

    function automatic logic [PTR_W-1:0] inc_wrap(input logic [PTR_W-1:0] v);
        return (v == PTR_W'(NUM_REQ - 1)) ? '0 : v + 1'b1;
    endfunction

`ifdef RR_ARB_LOCK_EN
    logic [PTR_W-1:0] owner, owner_n;
`else
    logic unused_sink;
    assign unused_sink = ^{lock, state};
`endif

    // A requester acked this cycle sits out one edge so it can drop req.
    assign elig = req & ~ack;

    always_comb begin
        state_n   = IDLE;
        ptr_n     = ptr;
        ack_n     = '0;
        wr_en_n   = '0;
        wr_data_n = '0;
        busy_n    = 1'b0;
        found     = 1'b0;
        w         = '0;
        w_addr    = '0;
        idx       = 0;
`ifdef RR_ARB_LOCK_EN
        owner_n   = owner;
`endif
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(ptr) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (!found && elig[idx]) begin
                found = 1'b1;
                w     = PTR_W'(idx);
            end
        end
`ifdef RR_ARB_LOCK_EN
        // The owner streams freely: no ack mask while locked.
        if (state == LOCKED) begin
            found = req[owner];
            w     = owner;
        end
`endif
        if (found) begin
            w_addr           = req_addr[int'(w)*ADDR_W +: ADDR_W];
            ack_n[w]         = 1'b1;
            wr_en_n[w_addr]  = 1'b1;
            wr_data_n        = req_data[int'(w)*DATA_W +: DATA_W];
            busy_n           = 1'b1;
            ptr_n            = inc_wrap(w);
            state_n          = GRANT;
        end
`ifdef RR_ARB_LOCK_EN
        if (state == LOCKED) begin
            if (lock[owner]) begin
                state_n = LOCKED;
                ptr_n   = ptr;
            end else begin
                ptr_n   = inc_wrap(owner);
                state_n = found ? GRANT : IDLE;
            end
        end else if (found && lock[w]) begin
            state_n = LOCKED;
            owner_n = w;
        end
`endif
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            ptr     <= '0;
            ack     <= '0;
            wr_en   <= '0;
            wr_data <= '0;
            busy    <= 1'b0;
`ifdef RR_ARB_LOCK_EN
            owner   <= '0;
`endif
        end else begin
            state   <= state_n;
            ptr     <= ptr_n;
            ack     <= ack_n;
            wr_en   <= wr_en_n;
            wr_data <= wr_data_n;
            busy    <= busy_n;
`ifdef RR_ARB_LOCK_EN
            owner   <= owner_n;
`endif
        end
    end

endmodule

// File: doc/rr_reg_write_arbiter.md
Name: rr_reg_write_arbiter

Overview:
- Round-robin write arbiter that shares one bank of flip-flop registers (2**ADDR_W words, DATA_W bits each) between NUM_REQ requesters.
- Selects at most one requester per cycle and decodes its address into a one-hot register write enable.
- Drives the shared write data and returns a one-cycle ack to the winner.
- Sits between requester logic and the register bank. The bank's per-register load enables and data inputs are driven only by this block.

Parameters:
- NUM_REQ, 4, number of requesters (2..16)
- ADDR_W, 2, register address width; bank depth = 2**ADDR_W
- DATA_W, 8, register data width

Ports:
- clock  input  1  single clock; all state updates on posedge
- reset  input  1  asynchronous, active-low reset
- req  input  NUM_REQ  per-requester write request, level, held until ack
- req_addr  input  NUM_REQ*ADDR_W  flattened; requester i at [i*ADDR_W +: ADDR_W]
- req_data  input  NUM_REQ*DATA_W  flattened; requester i at [i*DATA_W +: DATA_W]
- lock  input  NUM_REQ  per-requester ownership hold (see Optional Feature)
- ack  output  NUM_REQ  one-hot, registered; high for one cycle per accepted write
- wr_en  output  2**ADDR_W  one-hot, registered; load enable for the bank register
- wr_data  output  DATA_W  registered; data for the bank register
- busy  output  1  registered; high in any cycle where ack != 0

Behaviour:
- Reset (reset low, asynchronous, any time including mid-write):
  - ack, wr_en, wr_data and busy go to 0.
  - Round-robin pointer ptr goes to 0.
  - FSM goes to IDLE.
  - Takes effect immediately; no write is issued in the cycle reset deasserts.
- Eligibility: eff_req = req & ~ack. A requester whose ack is currently high is not eligible at this edge, which prevents a double write while it drops req.
- Winner: first i in eff_req, searched from ptr upward with wrap (ptr, ptr+1, ..., NUM_REQ-1, 0, ..., ptr-1).
- On a posedge with a winner w:
  - ack <= onehot(w)
  - wr_en <= onehot(req_addr[w])
  - wr_data <= req_data[w]
  - busy <= 1
  - ptr <= (w+1) mod NUM_REQ
- On a posedge with no winner: ack, wr_en and wr_data go to 0; busy goes to 0; ptr is unchanged.
- Latency: a request sampled at edge N produces ack/wr_en/wr_data valid from edge N to edge N+1. The bank captures at edge N+1.
- Throughput: one write per cycle aggregate. A single isolated requester gets at most one write every 2 cycles, because of the ack mask.
- Fairness: a requester holding req is granted within NUM_REQ-1 grants to others (lock disabled).
- Address collisions: simultaneous requests to the same address are serialised in round-robin order; the last write wins.
- Outputs are mutually consistent: popcount(ack) == popcount(wr_en) <= 1.
- wr_data is 0 whenever wr_en == 0.
- FSM states: IDLE (no winner last edge), GRANT (single grant issued), LOCKED (only with the macro). Without the macro, LOCKED is unreachable.

Optional Feature:
- Macro: RR_ARB_LOCK_EN
- Defined:
  - If the winner w has lock[w]=1 at its grant edge, the FSM enters LOCKED with owner=w.
  - In LOCKED, only the owner is eligible and the ack mask is not applied to it. Each cycle owner req=1 is a new streamed write: one write per cycle, addr/data re-sampled every edge.
  - Cycles with owner req=0 produce no write.
  - Exit when lock[owner]=0 is sampled: that edge still processes the owner's req if high, then ptr <= owner+1 and the FSM returns to GRANT or IDLE.
  - Reset clears LOCKED.
- Not defined: the lock port is present but ignored; plain round-robin only.

Test Plan:
- Reset mid-write: req=4'b0001, addr0=2, data0=8'hA5; assert reset low between edges while ack=1 -> ack, wr_en, wr_data and busy drop to 0 immediately; no write after release until req is re-sampled.
- Single request: req0=1, addr=3, data=8'h3C -> next cycle ack=4'b0001, wr_en=4'b1000, wr_data=8'h3C; next edge outputs 0 even with req0 still high; re-granted on the following edge.
- All four request from reset, held until acked -> acks in order 0,1,2,3 on 4 consecutive cycles; ptr=0 afterwards.
- Fairness: req0 and req2 held continuously -> grants alternate 0,2,0,2; neither waits more than 1 grant.
- Collision: req1 and req3 both addr=1, data 8'h11 and 8'h33, ptr=0 -> wr_en=4'b0010 twice, data 8'h11 then 8'h33.
- With RR_ARB_LOCK_EN: req1 and lock1 held 3 cycles, req2 high throughout -> ack1 on 3 consecutive cycles; ack2 on the cycle after lock1 drops. Without the macro: ack1 and ack2 alternate.
